if_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the five-stage LoongArch pipeline. It sits between the PC generator and ID, and drives the SRAM-like instruction interface with up to OUTSTANDING requests in flight. Returned instructions go into a QDEPTH-entry queue, so fetch runs ahead of ID stalls. Branch and exception redirects drop queued entries and discard in-flight responses with a counter, not with single-request throw flags.

---
 rtl/if_fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_if_fetch_queue.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch front end. It issues SRAM-like fetch requests, keeping up
// to OUTSTANDING of them in flight. Returned words are buffered in a
// QDEPTH-entry queue feeding ID. Redirects empty the queue. Any responses
// still in flight at that point are dropped by a discard counter as they
// arrive.
//
// Optional feature, enabled by the macro IF_FQ_BYPASS_EN:
//   When the queue is empty and nothing is pending discard, a response is
//   forwarded combinationally to ID in the cycle it arrives.
//
// Ports
//   clk, resetn                  clock, async active-low reset
//   br_valid/br_pc               ID branch redirect (pulse) and target
//   flush_valid/flush_pc         WB exception/ertn redirect; wins over branch
//   inst_sram_*                  SRAM-like instruction port (read only)
//   if_to_id_valid/_bus          queue head to ID: {adef, inst, pc}
//   id_allowin                   ID takes the head this cycle
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int          OUTSTANDING = 2,
  parameter int          QDEPTH      = 4,
  parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_to_id_valid,
  input  logic        id_allowin,
  output logic [64:0] if_to_id_bus
);

  localparam int CW  = $clog2(OUTSTANDING) + 1;
  localparam int QW  = $clog2(QDEPTH) + 1;
  localparam int FPW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int QPW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CW-1:0] OUT_W   = CW'(OUTSTANDING);
  localparam logic [QW:0]   QDEP_W  = (QW+1)'(QDEPTH);

  logic [31:0]    fpc;
  logic           halt;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  discard;
  logic [QW-1:0]  qcount;
  logic [31:0]    pc_fifo [OUTSTANDING];
  logic [FPW-1:0] pf_wr, pf_rd;
  logic [64:0]    q_mem [QDEPTH];
  logic [QPW-1:0] q_wr, q_rd;

  logic        redirect, aligned, q_valid, q_full;
  logic        hs, resp, resp_live, adef_push, q_push, q_pop, byp_take;
  logic [31:0] target;
  logic [QW:0] used;
  logic [64:0] resp_entry, push_entry;

  function automatic logic [FPW-1:0] pf_next(input logic [FPW-1:0] p);
    return (p == FPW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [QPW-1:0] q_next(input logic [QPW-1:0] p);
    return (p == QPW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fpc;

  assign redirect = br_valid | flush_valid;
  assign target   = flush_valid ? flush_pc : br_pc;
  assign aligned  = (fpc[1:0] == 2'b00);
  assign q_valid  = (qcount != '0);
  assign q_full   = (qcount == QW'(QDEPTH));
  // Credit: every in-flight request already owns a queue slot.
  assign used     = (QW+1)'(inflight) + (QW+1)'(qcount);

  assign inst_sram_req = resetn & ~redirect & ~halt & aligned &
                         (inflight < OUT_W) & (used < QDEP_W);
  assign hs        = inst_sram_req & inst_sram_addr_ok;
  // A response with nothing in flight is a protocol error and is ignored.
  assign resp      = inst_sram_data_ok & (inflight != '0);
  assign resp_live = resp & (discard == '0) & ~redirect;
  assign adef_push = ~redirect & ~halt & ~aligned & (inflight == '0) & ~q_full;

  assign resp_entry = {1'b0, inst_sram_rdata, pc_fifo[pf_rd]};
  assign push_entry = adef_push ? {1'b1, 32'h0, fpc} : resp_entry;

`ifdef IF_FQ_BYPASS_EN
  logic byp;
  assign byp      = resp_live & ~q_valid;
  assign byp_take = byp & id_allowin;
  always_comb begin
    if_to_id_valid = q_valid | byp;
    if_to_id_bus   = '0;
    if (q_valid)  if_to_id_bus = q_mem[q_rd];
    else if (byp) if_to_id_bus = resp_entry;
  end
`else
  assign byp_take = 1'b0;
  always_comb begin
    if_to_id_valid = q_valid;
    if_to_id_bus   = '0;
    if (q_valid) if_to_id_bus = q_mem[q_rd];
  end
`endif

  assign q_pop  = q_valid & id_allowin;
  assign q_push = (resp_live & ~byp_take) | adef_push;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fpc      <= RESET_PC;
      halt     <= 1'b0;
      inflight <= '0;
      discard  <= '0;
      qcount   <= '0;
      pf_wr    <= '0;
      pf_rd    <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
    end else begin
      inflight <= inflight + CW'(hs) - CW'(resp);
      if (hs)   pf_wr <= pf_next(pf_wr);
      if (resp) pf_rd <= pf_next(pf_rd);
      if (redirect) begin
        fpc     <= target;
        halt    <= 1'b0;
        // Everything still outstanding after this cycle belongs to the old path.
        discard <= inflight - CW'(resp);
        qcount  <= '0;
        q_wr    <= '0;
        q_rd    <= '0;
      end else begin
        if (hs)                        fpc     <= fpc + 32'd4;
        if (adef_push)                 halt    <= 1'b1;
        if (resp && discard != '0)     discard <= discard - 1'b1;
        qcount <= qcount + QW'(q_push) - QW'(q_pop);
        if (q_push) q_wr <= q_next(q_wr);
        if (q_pop)  q_rd <= q_next(q_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs)                  pc_fifo[pf_wr] <= fpc;
    if (q_push && !redirect) q_mem[q_wr]    <= push_entry;
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    inst_sram_data_ok |-> (inflight != '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
// Bench for if_fetch_queue with a behavioural SRAM (configurable accept and
// response latency) and a scoreboard of expected ID entries.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
`ifdef IF_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_pc = 32'h0;
  logic        flush_valid = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        if_to_id_valid;
  logic        id_allowin = 1'b0;
  logic [64:0] if_to_id_bus;

  if_fetch_queue #(.OUTSTANDING(2), .QDEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn),
    .br_valid(br_valid), .br_pc(br_pc),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .if_to_id_valid(if_to_id_valid), .id_allowin(id_allowin),
    .if_to_id_bus(if_to_id_bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int pop_cnt = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int lat = 1;
  bit ok_mode = 1'b1;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;
  pend_t       pend[$];
  logic [64:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
  endfunction

  function automatic logic [64:0] exp_entry(input logic [31:0] pc);
    return {1'b0, mem_word(pc), pc};
  endfunction

  // SRAM: record handshakes mid-cycle, answer in order after lat cycles.
  always @(negedge clk) begin
    if (resetn && inst_sram_req && inst_sram_addr_ok) begin
      pend.push_back('{inst_sram_addr, cyc + lat});
      hs_cnt++;
    end
    if (inst_sram_data_ok && pend.size() > 0) void'(pend.pop_front());
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    inst_sram_addr_ok = ok_mode;
    if (!resetn) begin
      pend.delete();
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_word(pend[0].a);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
  end

  // Scoreboard consumer: every entry ID takes must be the next expected one.
  always @(negedge clk) begin
    logic [64:0] e;
    if (resetn && if_to_id_valid && id_allowin) begin
      if (pop_cnt == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pop_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL id_unexpected: got %h, required no entry", if_to_id_bus);
      end else begin
        e = exp_q.pop_front();
        if (if_to_id_bus !== e) begin
          errors++;
          $display("FAIL id_entry: got %h, required %h", if_to_id_bus, e);
        end
      end
    end
  end

  task automatic hold_reset(input int l, input bit ok, input logic allow);
    @(posedge clk); #2;
    resetn = 1'b0; br_valid = 1'b0; flush_valid = 1'b0;
    id_allowin = allow; lat = l; ok_mode = ok;
    #1;
    checks++;
    if (inst_sram_req !== 1'b0) begin
      errors++; $display("FAIL rst_req: got %b, required 0", inst_sram_req);
    end
    checks++;
    if (if_to_id_valid !== 1'b0 || if_to_id_bus !== 65'h0) begin
      errors++; $display("FAIL rst_id: got %b/%h, required 0/0", if_to_id_valid, if_to_id_bus);
    end
    checks++;
    if (inst_sram_addr !== RESET_PC) begin
      errors++; $display("FAIL rst_addr: got %h, required %h", inst_sram_addr, RESET_PC);
    end
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete(); hs_cnt = 0; pop_cnt = 0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #2; n++;
    end
    id_allowin = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_drain: got %0d left, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    hold_reset(1, 1'b1, 1'b0);
    checks++;
    if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL const_ports: got %b %b %h %h, required 0 10 0 0",
               inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, RESET_PC}) begin
      errors++; $display("FAIL first_req: got %b/%h, required 1/%h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
  endtask

  task automatic test_stream;
    bit found = 1'b0;
    hold_reset(1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_entry(RESET_PC + 32'(4 * i)));
    resetn = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (inst_sram_data_ok) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stream_dataok: got none, required data_ok within 10 cycles"); end
    checks++;
    if (if_to_id_valid !== BYP) begin
      errors++; $display("FAIL lat_same_cycle: got %b, required %b", if_to_id_valid, BYP);
    end
    @(negedge clk);
    checks++;
    if (if_to_id_valid !== 1'b1) begin
      errors++; $display("FAIL lat_next_cycle: got %b, required 1", if_to_id_valid);
    end
    wait_drain(40, "stream");
    checks++;
    if (last_pop_cyc - first_pop_cyc != 7) begin
      errors++; $display("FAIL throughput: got %0d cycles, required 7", last_pop_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_backpressure;
    hold_reset(1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_entry(RESET_PC + 32'(4 * i)));
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (hs_cnt != 4) begin errors++; $display("FAIL bp_accepts: got %0d, required 4", hs_cnt); end
    @(negedge clk);
    checks++;
    if ({inst_sram_req, if_to_id_valid} !== 2'b01) begin
      errors++; $display("FAIL bp_stall: got req/valid %b/%b, required 0/1", inst_sram_req, if_to_id_valid);
    end
    @(posedge clk); #2;
    id_allowin = 1'b1;
    wait_drain(40, "bp");
  endtask

  task automatic test_branch;
    int n = 0;
    hold_reset(3, 1'b1, 1'b1);
    resetn = 1'b1;
    while (hs_cnt < 2 && n < 10) begin @(posedge clk); #2; n++; end
    checks++;
    if (hs_cnt != 2) begin errors++; $display("FAIL br_inflight: got %0d, required 2", hs_cnt); end
    br_valid = 1'b1; br_pc = 32'h1c000100;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(32'h1c000100 + 32'(4 * i)));
    @(negedge clk);
    checks++;
    if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL br_req_forced: got %b, required 0", inst_sram_req); end
    @(posedge clk); #2;
    br_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.discard !== 2'd2) begin errors++; $display("FAIL br_discard: got %0d, required 2", dut.discard); end
    wait_drain(60, "br");
    checks++;
    if (dut.discard !== 2'd0) begin errors++; $display("FAIL br_discard_end: got %0d, required 0", dut.discard); end
  endtask

  task automatic test_flush_beats_branch;
    int n = 0;
    hold_reset(2, 1'b1, 1'b1);
    resetn = 1'b1;
    do begin @(posedge clk); #2; n++; end while (!inst_sram_data_ok && n < 10);
    checks++;
    if (!inst_sram_data_ok) begin errors++; $display("FAIL fl_dataok: got 0, required 1"); end
    flush_valid = 1'b1; flush_pc = 32'h1c008000;
    br_valid    = 1'b1; br_pc    = 32'h1c000200;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(32'h1c008000 + 32'(4 * i)));
    @(negedge clk);
    checks++;
    if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL fl_req_forced: got %b, required 0", inst_sram_req); end
    @(posedge clk); #2;
    flush_valid = 1'b0; br_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({inst_sram_req, inst_sram_addr} !== {1'b1, 32'h1c008000}) begin
      errors++; $display("FAIL fl_new_req: got %b/%h, required 1/1c008000", inst_sram_req, inst_sram_addr);
    end
    checks++;
    if (dut.discard !== 2'd1) begin errors++; $display("FAIL fl_discard: got %0d, required 1", dut.discard); end
    wait_drain(40, "fl");
  endtask

  task automatic test_misaligned;
    int hs_before;
    hold_reset(1, 1'b1, 1'b0);
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    br_valid = 1'b1; br_pc = 32'h1c000102;
    @(posedge clk); #2;
    br_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL adef_noreq: got %b, required 0", inst_sram_req); end
    exp_q.push_back({1'b1, 32'h0, 32'h1c000102});
    @(posedge clk); #2;
    hs_before = hs_cnt;
    id_allowin = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (hs_cnt != hs_before || pop_cnt != 1) begin
      errors++; $display("FAIL adef_halt: got %0d requests/%0d pops, required 0/1", hs_cnt - hs_before, pop_cnt);
    end
    flush_valid = 1'b1; flush_pc = 32'h1c000400;
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_entry(32'h1c000400 + 32'(4 * i)));
    @(posedge clk); #2;
    flush_valid = 1'b0;
    wait_drain(40, "adef");
  endtask

`ifdef IF_FQ_BYPASS_EN
  task automatic test_bypass;
    bit found = 1'b0;
    hold_reset(1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(RESET_PC + 32'(4 * i)));
    resetn = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (inst_sram_data_ok) found = 1'b1;
    end
    checks++;
    if (!found || if_to_id_valid !== 1'b1 || if_to_id_bus !== exp_entry(RESET_PC)) begin
      errors++; $display("FAIL byp_same_cycle: got %b/%h, required 1/%h", if_to_id_valid, if_to_id_bus, exp_entry(RESET_PC));
    end
    checks++;
    if (dut.qcount !== '0) begin errors++; $display("FAIL byp_qcount: got %0d, required 0", dut.qcount); end
    @(negedge clk);
    checks++;
    if (dut.qcount !== '0) begin errors++; $display("FAIL byp_qcount2: got %0d, required 0", dut.qcount); end
    wait_drain(40, "byp");
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_flush_beats_branch();
    test_misaligned();
`ifdef IF_FQ_BYPASS_EN
    test_bypass();
`endif
    hold_reset(1, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
